// File: rtl/gmii_buf_pkg.sv
// Shared types and constants for the GMII transmit scheduler.
// Buffer word layout is {en, d[7:0], er}.
package gmii_buf_pkg;
  localparam int NUM_CH  = 4;
  localparam int FIFO_W  = 10;
  localparam int EN_BIT  = 9;
  localparam int ER_BIT  = 0;
  localparam int DAT_LSB = 1;
  localparam int DAT_MSB = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    READ,
    DRAIN,
    GAP
  } state_e;
endpackage

// File: rtl/gmii_tx_sched_rr_arb4.sv
// Rotating-priority encoder over four requesters.
// Search starts just above the last granted index and wraps.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any
);
  logic [1:0] cand;
  logic       hit;

  // First requester found walking upward from last+1
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    hit     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!hit && req[cand]) begin
        gnt_idx = cand;
        hit     = 1'b1;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/gmii_tx_sched.sv
// Frame-granular round-robin scheduler feeding one GMII tx port
// from four channel buffers with companion length queues.
module gmii_tx_sched
  import gmii_buf_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int RD_LAT  = 1,
  parameter int IPG_CYC = 8
) (
  input  logic                       gmii_tx_clk,
  input  logic                       tx_rst,
  input  logic [NUM_CH-1:0]          len_valid,
  input  logic [NUM_CH*LEN_W-1:0]    len_data,
  output logic [NUM_CH-1:0]          len_pop,
  output logic [NUM_CH-1:0]          fifo_rd_en,
  input  logic [NUM_CH*FIFO_W-1:0]   fifo_rd_data,
  output logic [7:0]                 gmii_txd,
  output logic                       gmii_tx_en,
  output logic                       gmii_tx_er,
  output logic                       busy,
  output logic [1:0]                 cur_ch,
  output logic                       frame_done,
  output logic                       zero_len_drop,
  output logic                       underrun
);
  localparam int TMR_W = 8;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [1:0]         cur_ch_q, cur_ch_d;
  logic [1:0]         last_q, last_d;

  logic [1:0]         arb_idx;
  logic               arb_any;
  logic [LEN_W-1:0]   lens  [NUM_CH];
  logic [FIFO_W-1:0]  words [NUM_CH];
  logic [LEN_W-1:0]   len_sel;
  logic               rd_any;
  logic               rd_last;

  logic               vld_q [RD_LAT];
  logic               lst_q [RD_LAT];
  logic [1:0]         pch_q [RD_LAT];
  logic [FIFO_W-1:0]  word;

  logic [7:0]         txd_q;
  logic               en_q, er_q, done_q, udr_q;

  rr_arb4 u_arb (
    .req     (len_valid),
    .last    (last_q),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Unpack the flat per-channel buses into indexable arrays
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      lens[k]  = len_data[k*LEN_W +: LEN_W];
      words[k] = fifo_rd_data[k*FIFO_W +: FIFO_W];
    end
  end

  assign len_sel = lens[cur_ch_q];
  assign rd_any  = (state_q == READ);
  assign rd_last = rd_any && (cnt_q == LEN_W'(1));

  // State register
  always_ff @(posedge gmii_tx_clk or posedge tx_rst) begin
    if (tx_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: zero-length entries return to IDLE with no gap
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = GRANT;
      GRANT:   state_d = (len_sel == '0) ? IDLE : READ;
      READ:    if (cnt_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (tmr_q == TMR_W'(RD_LAT)) state_d = GAP;
      GAP:     if (tmr_q == TMR_W'(IPG_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    len_pop       = '0;
    fifo_rd_en    = '0;
    zero_len_drop = 1'b0;
    busy          = (state_q != IDLE);
    unique case (state_q)
      GRANT: begin
        len_pop[cur_ch_q] = 1'b1;
        zero_len_drop     = (len_sel == '0);
      end
      READ:    fifo_rd_en[cur_ch_q] = 1'b1;
      default: ;
    endcase
  end

  // Next values for word counter, phase timer and grant pointers
  always_comb begin
    cnt_d    = cnt_q;
    cur_ch_d = cur_ch_q;
    last_d   = last_q;
    tmr_d    = (state_d != state_q) ? '0 : tmr_q + TMR_W'(1);
    if (state_q == IDLE && arb_any) cur_ch_d = arb_idx;
    if (state_q == GRANT) begin
      cnt_d  = len_sel;
      last_d = cur_ch_q;
    end else if (state_q == READ) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  // Counter and grant registers; ch0 wins first after reset
  always_ff @(posedge gmii_tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      cnt_q    <= '0;
      tmr_q    <= '0;
      cur_ch_q <= '0;
      last_q   <= 2'd3;
    end else begin
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      cur_ch_q <= cur_ch_d;
      last_q   <= last_d;
    end
  end

  // Valid/last/channel tags travel alongside the buffer read latency
  always_ff @(posedge gmii_tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        lst_q[i] <= 1'b0;
        pch_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_any;
      lst_q[0] <= rd_last;
      pch_q[0] <= cur_ch_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
        pch_q[i] <= pch_q[i-1];
      end
    end
  end

  assign word = words[pch_q[RD_LAT-1]];

  // Output register: a word with en=0 becomes an error byte
  always_ff @(posedge gmii_tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      txd_q  <= '0;
      en_q   <= 1'b0;
      er_q   <= 1'b0;
      done_q <= 1'b0;
      udr_q  <= 1'b0;
    end else begin
      en_q   <= vld_q[RD_LAT-1];
      txd_q  <= vld_q[RD_LAT-1] ? word[DAT_MSB:DAT_LSB] : '0;
      er_q   <= vld_q[RD_LAT-1] &
                (word[ER_BIT] | ~word[EN_BIT]);
      udr_q  <= vld_q[RD_LAT-1] & ~word[EN_BIT];
      done_q <= vld_q[RD_LAT-1] & lst_q[RD_LAT-1];
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;
  assign frame_done = done_q;
  assign underrun   = udr_q;
  assign cur_ch     = cur_ch_q;
endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched with a buffer model and
// a byte scoreboard; a second instance covers RD_LAT=3 timing.
module tb_gmii_tx_sched;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic tx_rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    len_valid = '0;
  logic [4*LW-1:0] len_data = '0;
  logic [3:0]    len_pop, fifo_rd_en;
  logic [39:0]   fifo_rd_data = '0;
  logic [7:0]    gmii_txd;
  logic          gmii_tx_en, gmii_tx_er, busy;
  logic [1:0]    cur_ch;
  logic          frame_done, zero_len_drop, underrun;
  logic [23:0]   all_out;

  gmii_tx_sched #(.LEN_W(LW), .RD_LAT(1), .IPG_CYC(8)) dut (
    .gmii_tx_clk(clk), .tx_rst(tx_rst),
    .len_valid(len_valid), .len_data(len_data),
    .len_pop(len_pop), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er), .busy(busy), .cur_ch(cur_ch),
    .frame_done(frame_done), .zero_len_drop(zero_len_drop),
    .underrun(underrun)
  );

  assign all_out = {len_pop, fifo_rd_en, gmii_txd, gmii_tx_en,
                    gmii_tx_er, busy, cur_ch, frame_done,
                    zero_len_drop, underrun};

  // RD_LAT=3 instance: ch0 only, two frames of 16 words
  logic [3:0]    len_valid3, len_pop3, fifo_rd_en3;
  logic [4*LW-1:0] len_data3;
  logic [39:0]   fifo_rd_data3;
  logic [7:0]    txd3;
  logic          en3, er3, busy3, done3, zl3, udr3;
  logic [1:0]    cur3;
  int            f3_left = 2;
  logic [9:0]    d3 [3];
  logic [7:0]    b3;

  gmii_tx_sched #(.LEN_W(LW), .RD_LAT(3), .IPG_CYC(8)) dut3 (
    .gmii_tx_clk(clk), .tx_rst(tx_rst),
    .len_valid(len_valid3), .len_data(len_data3),
    .len_pop(len_pop3), .fifo_rd_en(fifo_rd_en3),
    .fifo_rd_data(fifo_rd_data3),
    .gmii_txd(txd3), .gmii_tx_en(en3), .gmii_tx_er(er3),
    .busy(busy3), .cur_ch(cur3), .frame_done(done3),
    .zero_len_drop(zl3), .underrun(udr3)
  );

  assign len_valid3    = {3'b000, f3_left != 0};
  assign len_data3     = {33'd0, 11'd16};
  assign fifo_rd_data3 = {30'd0, d3[2]};

  int checks = 0;
  int errors = 0;

  logic [9:0]  dq [4][$];
  int          lq [4][$];
  logic [12:0] sbq [$];
  logic [7:0]  sb3 [$];

  bit mon_on = 1'b1;
  int cyc = 0;
  int rd_cnt [4] = '{default: 0};
  int pop_cnt [4] = '{default: 0};
  int zl_cnt = 0, udr_cnt = 0, done_cnt = 0;
  int rd_log [$], pop_log [$], byte_log [$], gap_log [$];
  int rd3_log [$], byte3_log [$], gap3_log [$];
  int idle_run = 0, idle3 = 0;
  bit had_byte = 1'b0, had3 = 1'b0;
  logic [13:0] got, want;
  logic [8:0]  got3, want3;

  // Buffer model: RD_LAT=1 read data and length queue pops
  always @(posedge clk or posedge tx_rst) begin
    if (tx_rst) begin
      fifo_rd_data <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (fifo_rd_en[k])
          fifo_rd_data[k*10 +: 10] <=
            (dq[k].size() != 0) ? dq[k].pop_front() : 10'h0;
        if (len_pop[k] && lq[k].size() != 0)
          void'(lq[k].pop_front());
      end
    end
  end

  // Buffer model for the RD_LAT=3 instance
  always @(posedge clk or posedge tx_rst) begin
    if (tx_rst) begin
      for (int i = 0; i < 3; i++) d3[i] <= '0;
      b3 <= '0;
    end else begin
      d3[0] <= fifo_rd_en3[0] ? {1'b1, b3, 1'b0} : 10'h0;
      d3[1] <= d3[0];
      d3[2] <= d3[1];
      if (fifo_rd_en3[0]) b3 <= b3 + 8'd1;
      if (len_pop3[0] && f3_left > 0) f3_left <= f3_left - 1;
    end
  end

  // Present queue heads to the DUT
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      len_valid[k] = (lq[k].size() != 0);
      len_data[k*LW +: LW] =
        (lq[k].size() != 0) ? LW'(lq[k][0]) : '0;
    end
  end

  // Monitor: event logs and per-byte scoreboard compare
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (fifo_rd_en[k]) begin
        rd_cnt[k]++;
        rd_log.push_back(cyc);
      end
      if (len_pop[k]) begin
        pop_cnt[k]++;
        pop_log.push_back(cyc);
      end
    end
    if (zero_len_drop) zl_cnt++;
    if (underrun) udr_cnt++;
    if (frame_done) done_cnt++;
    if (gmii_tx_en) begin
      byte_log.push_back(cyc);
      if (had_byte && idle_run > 0) gap_log.push_back(idle_run);
      had_byte = 1'b1;
      idle_run = 0;
      if (mon_on) begin
        got  = {1'b1, gmii_txd, gmii_tx_er, frame_done,
                underrun, cur_ch};
        want = (sbq.size() != 0) ? {1'b1, sbq.pop_front()} : '0;
        checks++;
        assert (got === want) else begin
          errors++;
          $error("FAIL byte cyc=%0d got=%0h want=%0h",
                 cyc, got, want);
        end
      end
    end else begin
      idle_run++;
      if (mon_on) begin
        checks++;
        assert ({gmii_txd, gmii_tx_er, frame_done, underrun}
                === 11'h0) else begin
          errors++;
          $error("FAIL idle_out cyc=%0d got=%0h want=0", cyc,
                 {gmii_txd, gmii_tx_er, frame_done, underrun});
        end
      end
    end
    if (fifo_rd_en3[0]) rd3_log.push_back(cyc);
    if (en3) begin
      byte3_log.push_back(cyc);
      if (had3 && idle3 > 0) gap3_log.push_back(idle3);
      had3  = 1'b1;
      idle3 = 0;
      got3  = {1'b1, txd3};
      want3 = (sb3.size() != 0) ? {1'b1, sb3.pop_front()} : '0;
      checks++;
      assert (got3 === want3) else begin
        errors++;
        $error("FAIL u3_byte cyc=%0d got=%0h want=%0h",
               cyc, got3, want3);
      end
    end else begin
      idle3++;
    end
  end

  task automatic chk(input string tag, input longint g,
                     input longint w);
    checks++;
    assert (g === w) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, g, w);
    end
  endtask

  task automatic load_frame(input int ch, input int n,
                            input int base, input int bad,
                            input int erx);
    logic [9:0] w;
    lq[ch].push_back(n);
    for (int i = 0; i < n; i++) begin
      w = {(i != bad), 8'(base + i), (i == erx)};
      dq[ch].push_back(w);
      sbq.push_back({w[8:1], w[0] | ~w[9], (i == n - 1),
                     ~w[9], 2'(ch)});
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_wait", longint'(done_cnt >= target), 1);
    repeat (14) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
  endtask

  function automatic int dif(input int a [$], input int i,
                             input int b [$], input int j);
    if (a.size() > i && b.size() > j) return a[i] - b[j];
    return -999;
  endfunction

  initial begin
    int g0, r0, b0, p0, z0, u0, rc, pc, d0, n;
    for (int i = 0; i < 32; i++) sb3.push_back(8'(i));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", longint'(all_out), 0);
    tx_rst = 1'b0;

    // All four channels, back to back: order 0,1,2,3,0
    @(posedge clk); #1;
    g0 = gap_log.size();
    d0 = done_cnt;
    load_frame(0, 10, 8'h00, -1, -1);
    load_frame(1, 10, 8'h20, -1, -1);
    load_frame(2, 10, 8'h40, -1, 3);
    load_frame(3, 10, 8'h60, -1, -1);
    load_frame(0, 10, 8'h80, -1, -1);
    wait_done(d0 + 5, 600);
    for (int i = 0; i < 4; i++)
      chk("gap12", (gap_log.size() > g0 + i) ? gap_log[g0 + i] : -1,
          12);

    // RD_LAT=3 instance timing
    chk("u3_bytes", byte3_log.size(), 32);
    chk("u3_reads", rd3_log.size(), 32);
    chk("u3_lat0", dif(byte3_log, 0, rd3_log, 0), 4);
    chk("u3_lat1", dif(byte3_log, 16, rd3_log, 16), 4);
    chk("u3_gap14", (gap3_log.size() > 0) ? gap3_log[0] : -1, 14);

    // Single frame on ch2, 64 incrementing bytes from 0x55
    @(posedge clk); #1;
    r0 = rd_log.size();
    b0 = byte_log.size();
    rc = rd_cnt[2];
    pc = pop_cnt[2];
    d0 = done_cnt;
    load_frame(2, 64, 8'h55, -1, -1);
    wait_done(d0 + 1, 300);
    chk("ch2_reads", rd_cnt[2] - rc, 64);
    chk("ch2_pops", pop_cnt[2] - pc, 1);
    chk("ch2_lat", dif(byte_log, b0, rd_log, r0), 2);
    chk("ch2_contig", dif(byte_log, b0 + 63, byte_log, b0), 63);

    // ch1 zero-length entry then a 5-word frame
    @(posedge clk); #1;
    p0 = pop_log.size();
    z0 = zl_cnt;
    rc = rd_cnt[1];
    d0 = done_cnt;
    load_frame(1, 0, 0, -1, -1);
    load_frame(1, 5, 8'hA0, -1, -1);
    wait_done(d0 + 1, 200);
    chk("zl_pulse", zl_cnt - z0, 1);
    chk("zl_regrant", dif(pop_log, p0 + 1, pop_log, p0), 2);
    chk("zl_reads", rd_cnt[1] - rc, 5);

    // en=0 at word 7 of a 20-word frame on ch3
    @(posedge clk); #1;
    u0 = udr_cnt;
    d0 = done_cnt;
    load_frame(3, 20, 8'h10, 7, -1);
    wait_done(d0 + 1, 200);
    chk("underrun_cnt", udr_cnt - u0, 1);

    // Reset in the middle of a 100-word frame on ch1
    @(posedge clk); #1;
    rc = rd_cnt[1];
    load_frame(1, 100, 8'h00, -1, -1);
    n = 0;
    while (rd_cnt[1] - rc < 30 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("rst_reach30", longint'(rd_cnt[1] - rc >= 30), 1);
    #1;
    tx_rst = 1'b1;
    mon_on = 1'b0;
    #1;
    chk("rst_async_out", longint'(all_out), 0);
    sbq.delete();
    for (int k = 0; k < 4; k++) begin
      lq[k].delete();
      dq[k].delete();
    end
    repeat (3) @(posedge clk);
    #1;
    tx_rst = 1'b0;
    mon_on = 1'b1;
    d0 = done_cnt;
    load_frame(0, 4, 8'hB0, -1, -1);
    load_frame(3, 4, 8'hC0, -1, -1);
    wait_done(d0 + 2, 200);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
